// File: rtl/cpu_bus_responder_if.sv
// CPU external bus bundle: request lines from the CPU, read data and interrupt back.
// CPU_BUS_RESPONDER_FAULT_EN adds the registered bus_fault return line.
interface cpu_bus_responder_if;
   logic [31:0] address_from_cpu;
   logic [31:0] data_from_cpu;
   logic [3:0]  control_from_cpu;
   logic        interrupt_grant_from_cpu;
   logic [31:0] data_to_cpu;
   logic        interrupt_to_cpu;
`ifdef CPU_BUS_RESPONDER_FAULT_EN
   logic        bus_fault;

   modport master (output address_from_cpu, data_from_cpu, control_from_cpu,
                   interrupt_grant_from_cpu,
                   input  data_to_cpu, interrupt_to_cpu, bus_fault);
   modport slave  (input  address_from_cpu, data_from_cpu, control_from_cpu,
                   interrupt_grant_from_cpu,
                   output data_to_cpu, interrupt_to_cpu, bus_fault);
`else
   modport master (output address_from_cpu, data_from_cpu, control_from_cpu,
                   interrupt_grant_from_cpu,
                   input  data_to_cpu, interrupt_to_cpu);
   modport slave  (input  address_from_cpu, data_from_cpu, control_from_cpu,
                   interrupt_grant_from_cpu,
                   output data_to_cpu, interrupt_to_cpu);
`endif
endinterface

// File: rtl/cpu_bus_responder.sv
// CPU bus target: word RAM with byte lanes, memory-mapped timer, interrupt request/grant.
// Optional CPU_BUS_RESPONDER_FAULT_EN: one-cycle registered bus_fault on bad requests.
module cpu_bus_responder #(
   parameter int          RAM_DEPTH_WORDS = 1024,
   parameter logic [31:0] PERIPH_BASE     = 32'h8000_0000,
   parameter int          PRESCALE        = 1
) (
   input  logic               clk,
   input  logic               reset,
   cpu_bus_responder_if.slave bus
);
   localparam int          AW        = $clog2(RAM_DEPTH_WORDS);
   localparam int          PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [32:0] RAM_BYTES = 33'(RAM_DEPTH_WORDS) << 2;

   typedef struct packed {
      logic          rd;
      logic          wr;
      logic [1:0]    size;
      logic          ram_hit;
      logic          per_hit;
      logic          bad;
      logic [AW-1:0] widx;
      logic [1:0]    off;
   } req_t;

   typedef enum logic {IDLE, PENDING} pend_t;

   req_t        req;
   logic [3:0]  be;
   logic [31:0] wdata, rdata;
   logic [31:0] mem [RAM_DEPTH_WORDS];
   logic        ram_we, per_word, per_wr;
   logic        wr_count, wr_cmp, wr_ctrl, ctrl_clr;
   logic [31:0] count, compare;
   logic        en, chg, inc, pre_wrap, match;
   logic [PW-1:0] pre;
   pend_t       state, state_nxt;

   always_comb begin
      req.rd      = bus.control_from_cpu[0];
      req.wr      = bus.control_from_cpu[1];
      req.size    = bus.control_from_cpu[3:2];
      req.ram_hit = {1'b0, bus.address_from_cpu} < RAM_BYTES;
      req.per_hit = bus.address_from_cpu[31:4] == PERIPH_BASE[31:4];
      req.bad     = (req.size == 2'b01 && bus.address_from_cpu[0]) ||
                    (req.size == 2'b10 && bus.address_from_cpu[1:0] != 2'b00) ||
                    (req.size == 2'b11) || (req.rd && req.wr);
      req.widx    = bus.address_from_cpu[AW+1:2];
      req.off     = bus.address_from_cpu[3:2];
   end

   // Lane enables and lane-replicated store data
   always_comb begin
      be    = 4'b0000;
      wdata = bus.data_from_cpu;
      case (req.size)
         2'b00: begin
            be    = 4'b0001 << bus.address_from_cpu[1:0];
            wdata = {4{bus.data_from_cpu[7:0]}};
         end
         2'b01: begin
            be    = bus.address_from_cpu[1] ? 4'b1100 : 4'b0011;
            wdata = {2{bus.data_from_cpu[15:0]}};
         end
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   assign ram_we   = req.wr && !reset && req.ram_hit && !req.bad;
   assign per_word = req.per_hit && !req.ram_hit && req.size == 2'b10 && !req.bad;
   assign per_wr   = req.wr && per_word;
   assign wr_count = per_wr && req.off == 2'd0;
   assign wr_cmp   = per_wr && req.off == 2'd1;
   assign wr_ctrl  = per_wr && req.off == 2'd2;
   assign ctrl_clr = wr_ctrl && bus.data_from_cpu[1];

   always_ff @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (ram_we && be[i]) mem[req.widx][i*8 +: 8] <= wdata[i*8 +: 8];

   assign pre_wrap = pre == PW'(PRESCALE - 1);
   assign inc      = en && pre_wrap;
   // chg marks the cycle right after an increment, so a match fires once per pass
   assign match    = chg && en && count == compare;

   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= 32'h0;
         compare <= 32'hFFFF_FFFF;
         en      <= 1'b0;
         pre     <= '0;
         chg     <= 1'b0;
      end else begin
         chg <= 1'b0;
         if (en) pre <= pre_wrap ? '0 : pre + PW'(1);
         if (wr_count) begin
            count <= bus.data_from_cpu;
            pre   <= '0;
         end else if (inc) begin
            count <= count + 32'd1;
            chg   <= 1'b1;
         end
         if (wr_cmp)  compare <= bus.data_from_cpu;
         if (wr_ctrl) en      <= bus.data_from_cpu[0];
      end
   end

   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else       state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (match) state_nxt = PENDING;
         PENDING: if (!match && (bus.interrupt_grant_from_cpu || ctrl_clr)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.interrupt_to_cpu = state == PENDING;

   always_comb begin
      rdata = 32'h0;
      if (!reset && req.rd && !req.bad) begin
         if (req.ram_hit) rdata = mem[req.widx];
         else if (per_word)
            case (req.off)
               2'd0:    rdata = count;
               2'd1:    rdata = compare;
               2'd2:    rdata = {30'h0, state == PENDING, en};
               default: rdata = 32'h0;
            endcase
      end
   end

   assign bus.data_to_cpu = rdata;

`ifdef CPU_BUS_RESPONDER_FAULT_EN
   always_ff @(posedge clk)
      if (reset) bus.bus_fault <= 1'b0;
      else       bus.bus_fault <= (req.rd || req.wr) &&
                                  (req.bad || !(req.ram_hit || req.per_hit));
`endif
endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: RAM lanes, decode drops, timer match/PEND, reset.
module tb_cpu_bus_responder;
   localparam logic [31:0] P    = 32'h8000_0000;
   localparam logic [3:0]  RD   = 4'b1001;
   localparam logic [3:0]  WWR  = 4'b1010;
   localparam logic [3:0]  BWR  = 4'b0010;
   localparam logic [3:0]  HWR  = 4'b0110;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] v;

   cpu_bus_responder_if bus();
   cpu_bus_responder dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] c);
      @(negedge clk);
      bus.address_from_cpu = a;
      bus.data_from_cpu    = d;
      bus.control_from_cpu = c;
      @(negedge clk);
      bus.control_from_cpu = 4'b0000;
   endtask

   task automatic rd(input logic [31:0] a, input logic [3:0] c, output logic [31:0] d);
      bus.address_from_cpu = a;
      bus.control_from_cpu = c;
      #1 d = bus.data_to_cpu;
      bus.control_from_cpu = 4'b0000;
   endtask

   initial begin
      bus.address_from_cpu         = 32'h0;
      bus.data_from_cpu            = 32'h0;
      bus.control_from_cpu         = 4'b0000;
      bus.interrupt_grant_from_cpu = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      rd(P + 32'h4, RD, v);             chk("rst_rdata", v, 32'h0);
      chk("rst_irq", {31'h0, bus.interrupt_to_cpu}, 32'h0);
      reset = 1'b0;
      rd(P,          RD, v);            chk("rst_count", v, 32'h0);
      rd(P + 32'h4,  RD, v);            chk("rst_compare", v, 32'hFFFF_FFFF);
      rd(P + 32'h8,  RD, v);            chk("rst_ctrl", v, 32'h0);

      // RAM word / byte / half stores and dropped accesses
      bus_wr(32'h10, 32'hDEAD_BEEF, WWR);
      rd(32'h10, RD, v);                chk("word_wr", v, 32'hDEAD_BEEF);
      bus_wr(32'h10, 32'h1122_3344, WWR);
      bus_wr(32'h13, 32'h0000_00AA, BWR);
      rd(32'h10, RD, v);                chk("byte_wr", v, 32'hAA22_3344);
      rd(32'h13, 4'b0001, v);           chk("byte_rd", v, 32'hAA22_3344);
      bus_wr(32'h11, 32'h0000_5566, HWR);
`ifdef CPU_BUS_RESPONDER_FAULT_EN
      chk("fault_half", {31'h0, bus.bus_fault}, 32'h1);
      @(negedge clk);
      chk("fault_pulse", {31'h0, bus.bus_fault}, 32'h0);
`endif
      rd(32'h10, RD, v);                chk("half_misal", v, 32'hAA22_3344);
      bus_wr(32'h12, 32'h0000_5566, HWR);
      rd(32'h10, RD, v);                chk("half_wr", v, 32'h5566_3344);
      bus_wr(32'h12, 32'h0, WWR);
      rd(32'h10, RD, v);                chk("word_misal", v, 32'h5566_3344);
      bus_wr(32'h10, 32'h0, 4'b1110);
      rd(32'h10, RD, v);                chk("size11", v, 32'h5566_3344);
      bus_wr(32'h10, 32'h0, 4'b1011);
      rd(32'h10, RD, v);                chk("rd_wr_both", v, 32'h5566_3344);
      bus_wr(32'h1010, 32'h0, WWR);
`ifdef CPU_BUS_RESPONDER_FAULT_EN
      chk("fault_unmap", {31'h0, bus.bus_fault}, 32'h1);
`endif
      rd(32'h10, RD, v);                chk("unmap_alias", v, 32'h5566_3344);
      rd(32'h1010, RD, v);              chk("unmap_rd", v, 32'h0);
      rd(32'h10, 4'b1000, v);           chk("no_rd_bit", v, 32'h0);
      rd(P + 32'hC, RD, v);             chk("per_unused", v, 32'h0);
      rd(P + 32'h4, 4'b0001, v);        chk("per_byte_rd", v, 32'h0);
      bus_wr(P + 32'h4, 32'h0000_0001, BWR);
      rd(P + 32'h4, RD, v);             chk("per_byte_wr", v, 32'hFFFF_FFFF);

      // Timer match raises the interrupt one edge after COUNT reaches COMPARE
      bus_wr(P + 32'h4, 32'd5, WWR);
      bus_wr(P + 32'h8, 32'd1, WWR);
      v = 32'h0;
      for (int i = 0; i < 20; i++) begin
         rd(P, RD, v);
         if (v == 32'd5) break;
         @(negedge clk);
      end
      chk("cnt_hit5", v, 32'd5);
      chk("irq_before", {31'h0, bus.interrupt_to_cpu}, 32'h0);
      @(negedge clk);
      chk("irq_rise", {31'h0, bus.interrupt_to_cpu}, 32'h1);
      rd(P, RD, v);                     chk("cnt_6", v, 32'd6);
      rd(P + 32'h8, RD, v);             chk("ctrl_pend", v, 32'h3);
      repeat (3) @(negedge clk);
      chk("irq_hold", {31'h0, bus.interrupt_to_cpu}, 32'h1);
      bus.interrupt_grant_from_cpu = 1'b1;
      @(negedge clk);
      bus.interrupt_grant_from_cpu = 1'b0;
      chk("irq_grant", {31'h0, bus.interrupt_to_cpu}, 32'h0);
      repeat (5) @(negedge clk);
      chk("no_refire", {31'h0, bus.interrupt_to_cpu}, 32'h0);
      rd(P, RD, v);                     chk("cnt_run", v, 32'd15);

      // Grant in the match cycle: set wins
      bus_wr(P, 32'd4, WWR);
      @(negedge clk);
      rd(P, RD, v);                     chk("cnt_match", v, 32'd5);
      bus.interrupt_grant_from_cpu = 1'b1;
      @(negedge clk);
      bus.interrupt_grant_from_cpu = 1'b0;
      chk("set_wins", {31'h0, bus.interrupt_to_cpu}, 32'h1);

      // Reset while pending
      bus_wr(P, 32'h1234, WWR);
      chk("irq_pre_rst", {31'h0, bus.interrupt_to_cpu}, 32'h1);
      @(negedge clk);
      reset = 1'b1;
      rd(P, RD, v);                     chk("rd_in_rst", v, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      chk("rst2_irq", {31'h0, bus.interrupt_to_cpu}, 32'h0);
      rd(P, RD, v);                     chk("rst2_count", v, 32'h0);
      rd(P + 32'h8, RD, v);             chk("rst2_ctrl", v, 32'h0);
      rd(P + 32'h4, RD, v);             chk("rst2_compare", v, 32'hFFFF_FFFF);

      // COUNT wrap and write-over-increment
      bus_wr(P, 32'hFFFF_FFFF, WWR);
      bus_wr(P + 32'h8, 32'd1, WWR);
      rd(P, RD, v);                     chk("cnt_max", v, 32'hFFFF_FFFF);
      @(negedge clk);
      rd(P, RD, v);                     chk("cnt_wrap", v, 32'h0);
      bus_wr(P, 32'd7, WWR);
      rd(P, RD, v);                     chk("cnt_wr_wins", v, 32'd7);
      @(negedge clk);
      rd(P, RD, v);                     chk("cnt_after_wr", v, 32'd8);

      // CTRL write with bit1 clears PEND, EN kept
      bus_wr(P + 32'h4, 32'h20, WWR);
      for (int i = 0; i < 60; i++) begin
         if (bus.interrupt_to_cpu) break;
         @(negedge clk);
      end
      chk("irq_set2", {31'h0, bus.interrupt_to_cpu}, 32'h1);
      bus_wr(P + 32'h8, 32'd3, WWR);
      chk("ctrl_clr_irq", {31'h0, bus.interrupt_to_cpu}, 32'h0);
      rd(P + 32'h8, RD, v);             chk("ctrl_clr_rd", v, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
